// File: rtl/stream_downsizer_pkg.sv
// Shared definitions for the stream downsizer.
//   state_e  : FSM state encoding (IDLE, SEND)
//   log2ceil : ceiling log2 used to size the beat counter
package stream_downsizer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Smallest r with 2**r >= n (0 for n <= 1); constant-bounded loop.
  function automatic int unsigned log2ceil(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_downsizer_if.sv
// Handshake bundle around a stream downsizer.
//   s_*  : wide input stream  (valid/data from upstream, ready back)
//   m_*  : narrow output stream (valid/data/last to downstream, ready back)
//   master : the environment side (drives s_valid/s_data/m_ready)
//   slave  : the downsizer side   (drives s_ready/m_valid/m_data/m_last)
interface stream_downsizer_if #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
);

  logic                 s_valid;
  logic [IN_WIDTH-1:0]  s_data;
  logic                 s_ready;
  logic                 m_valid;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_last;
  logic                 m_ready;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/stream_downsizer_counter_param.sv
// Free-running beat counter with increment enable; wraps naturally at 2**WIDTH.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : advance the count by one this cycle
//   cnt_o  : current count
module stream_downsizer_counter_param #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stream_downsizer.sv
// Splits each IN_WIDTH input word into RATIO = IN_WIDTH/OUT_WIDTH output beats,
// least-significant beat first, flagging the final beat with m_last_o.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   s_valid_i/s_data_i      : offered input word
//   s_ready_o               : word accepted this cycle (combinational)
//   m_valid_o/m_data_o      : presented output beat (combinational from state)
//   m_last_o                : final beat of the current word
//   m_ready_i               : downstream takes the beat
module stream_downsizer
  import stream_downsizer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_valid_i,
  input  logic [IN_WIDTH-1:0]  s_data_i,
  output logic                 s_ready_o,
  output logic                 m_valid_o,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = log2ceil(RATIO);

  // Reject ratios that are not an exact power of two of at least 2.
  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("stream_downsizer: IN_WIDTH/OUT_WIDTH must be a power of two >= 2");
  end

  state_e               state_q;
  state_e               state_d;
  logic [IN_WIDTH-1:0]  hold_q;
  logic [IN_WIDTH-1:0]  hold_d;
  logic [CNT_W-1:0]     cnt_q;

  logic                 in_send_c;
  logic                 last_c;
  logic                 m_hs_c;
  logic                 s_hs_c;
  logic [RATIO-1:0][OUT_WIDTH-1:0] beats_c;

  // Beat counter; cleared by reset, advanced by every output handshake.
  stream_downsizer_counter_param #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .inc_i  (m_hs_c),
    .cnt_o  (cnt_q)
  );

  // Output and ready decode; s_ready in SEND frees the hold register as the last beat leaves.
  always_comb begin
    beats_c   = hold_q;
    in_send_c = (state_q == SEND);
    last_c    = in_send_c && (cnt_q == CNT_W'(RATIO - 1));
    m_valid_o = in_send_c;
    m_last_o  = last_c;
    m_data_o  = in_send_c ? beats_c[cnt_q] : '0;
    s_ready_o = in_send_c ? (last_c && m_ready_i) : 1'b1;
    m_hs_c    = in_send_c && m_ready_i;
    s_hs_c    = s_valid_i && s_ready_o;
  end

  // Next state; a new word can only arrive in SEND together with the last-beat handshake.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (s_hs_c) begin
          state_d = SEND;
          hold_d  = s_data_i;
        end
      end
      SEND: begin
        if (m_hs_c && last_c) begin
          if (s_hs_c) hold_d  = s_data_i;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and hold registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer (32 -> 8 bits).
module tb_stream_downsizer;

  logic clk;
  logic rst;

  stream_downsizer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus ();

  stream_downsizer #(
    .IN_WIDTH  (32),
    .OUT_WIDTH (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_valid_i (bus.s_valid),
    .s_data_i  (bus.s_data),
    .s_ready_o (bus.s_ready),
    .m_valid_o (bus.m_valid),
    .m_data_o  (bus.m_data),
    .m_last_o  (bus.m_last),
    .m_ready_i (bus.m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [31:0]     word;
    logic [3:0][7:0] beats;  // beats[0] is the first beat expected
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  // Checks one presented beat and the ready it should produce.
  task automatic check_beat(input string name, input logic [7:0] data, input logic last,
                            input logic s_rdy);
    check({name, ".valid"}, 32'(bus.m_valid), 32'd1);
    check({name, ".data"},  32'(bus.m_data),  32'(data));
    check({name, ".last"},  32'(bus.m_last),  32'(last));
    check({name, ".s_rdy"}, 32'(bus.s_ready), 32'(s_rdy));
  endtask

  task automatic check_idle(input string name);
    check({name, ".valid"}, 32'(bus.m_valid), 32'd0);
    check({name, ".data"},  32'(bus.m_data),  32'd0);
    check({name, ".last"},  32'(bus.m_last),  32'd0);
    check({name, ".s_rdy"}, 32'(bus.s_ready), 32'd1);
  endtask

  // Random-traffic scoreboard state.
  logic [7:0] exp_q[$];
  int         words_in;
  int         beats_out;
  int         cycles;
  logic       exp_valid;
  logic       exp_srdy;
  logic       mhs;
  logic       shs;
  logic [31:0] w;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    vecs[0] = '{32'hA1B2C3D4, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    vecs[1] = '{32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    vecs[2] = '{32'h11223344, {8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[3] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{32'hFFFFFFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[5] = '{32'h80000001, {8'h80, 8'h00, 8'h00, 8'h01}};

    // Reset state, sampled while reset is held.
    #3;
    check_idle("reset");
    do_reset();
    check_idle("post_reset");

    // Table: one word at a time with the consumer always ready.
    for (int v = 0; v < 6; v++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = vecs[v].word;
      bus.m_ready = 1'b1;
      #1;
      check($sformatf("vec%0d.accept_rdy", v), 32'(bus.s_ready), 32'd1);
      tick();
      bus.s_valid = 1'b0;
      bus.s_data  = 32'h5A5A5A5A;  // ignored while not ready
      for (int b = 0; b < 4; b++) begin
        #1;
        check_beat($sformatf("vec%0d.b%0d", v, b), vecs[v].beats[b], b == 3, b == 3);
        tick();
      end
      #1;
      check_idle($sformatf("vec%0d.done", v));
    end

    // Back-to-back words with no bubble.
    do_reset();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h03020100;
    bus.m_ready = 1'b1;
    tick();
    bus.s_data  = 32'h07060504;
    for (int b = 0; b < 8; b++) begin
      #1;
      check_beat($sformatf("b2b.b%0d", b), 8'(b), (b % 4) == 3, (b % 4) == 3);
      tick();
      if (b == 3) bus.s_valid = 1'b0;
    end
    #1;
    check_idle("b2b.done");

    // Downstream stall on beat 1.
    do_reset();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEADBEEF;
    bus.m_ready = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    #1;
    check_beat("stall.b0", 8'hEF, 1'b0, 1'b0);
    tick();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h12345678;  // must be ignored
    for (int c = 0; c < 3; c++) begin
      #1;
      check_beat($sformatf("stall.hold%0d", c), 8'hBE, 1'b0, 1'b0);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    check_beat("stall.b1", 8'hBE, 1'b0, 1'b0);
    tick();
    #1;
    check_beat("stall.b2", 8'hAD, 1'b0, 1'b0);
    tick();
    #1;
    check_beat("stall.b3", 8'hDE, 1'b1, 1'b1);
    tick();
    #1;
    check_idle("stall.done");

    // Asynchronous reset mid-word, then a fresh word.
    do_reset();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEADBEEF;
    bus.m_ready = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    #1;
    check_beat("arst.b0", 8'hEF, 1'b0, 1'b0);
    tick();
    #1;
    check_beat("arst.b1", 8'hBE, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_idle("arst.during");
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_idle("arst.after");
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h11223344;
    tick();
    bus.s_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      check_beat($sformatf("arst.new%0d", b), 8'(32'h11223344 >> (8 * b)), b == 3, b == 3);
      tick();
    end
    #1;
    check_idle("arst.done");

    // Random traffic against a byte-queue scoreboard.
    do_reset();
    words_in  = 0;
    beats_out = 0;
    cycles    = 0;
    exp_q.delete();
    while ((words_in < 1000 || exp_q.size() != 0) && cycles < 20000) begin
      bus.s_valid = (words_in < 1000) && ($urandom_range(0, 9) < 7);
      w           = $urandom;
      bus.s_data  = w;
      bus.m_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_valid = (exp_q.size() != 0);
      exp_srdy  = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.m_ready);
      check("rnd.valid", 32'(bus.m_valid), 32'(exp_valid));
      check("rnd.s_rdy", 32'(bus.s_ready), 32'(exp_srdy));
      if (exp_valid) begin
        check("rnd.data", 32'(bus.m_data), 32'(exp_q[0]));
        check("rnd.last", 32'(bus.m_last), 32'((beats_out % 4) == 3));
      end
      mhs = exp_valid && bus.m_ready;
      shs = bus.s_valid && exp_srdy;
      tick();
      cycles++;
      if (mhs) begin
        void'(exp_q.pop_front());
        beats_out++;
      end
      if (shs) begin
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
        words_in++;
      end
    end
    check("rnd.words", 32'(words_in), 32'd1000);
    check("rnd.beats", 32'(beats_out), 32'd4000);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 32, meaning the width of an accepted input word.
REQ-002 The module SHALL have parameter OUT_WIDTH, default 8, meaning the width of an emitted output beat.
REQ-003 The module SHALL have the port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have the port rst_i, input, 1 bit, an asynchronous active-high reset.
REQ-005 The module SHALL have the port s_valid_i, input, 1 bit, meaning an input word is offered.
REQ-006 The module SHALL have the port s_data_i, input, IN_WIDTH bits, meaning the offered input word.
REQ-007 The module SHALL have the port s_ready_o, output, 1 bit, meaning the block accepts the word this cycle.
REQ-008 The module SHALL have the port m_valid_o, output, 1 bit, meaning an output beat is presented.
REQ-009 The module SHALL have the port m_data_o, output, OUT_WIDTH bits, meaning the presented beat.
REQ-010 The module SHALL have the port m_last_o, output, 1 bit, meaning the presented beat is the final beat of its word.
REQ-011 The module SHALL have the port m_ready_i, input, 1 bit, meaning the downstream consumer takes the beat.

Function
REQ-012 RATIO SHALL equal IN_WIDTH/OUT_WIDTH; RATIO must be a power of two, 2 or greater; violation -> elaboration error.
REQ-013 An input handshake SHALL occur when s_valid_i and s_ready_o are both high at a rising edge; an output handshake SHALL occur when m_valid_o and m_ready_i are both high.
REQ-014 FSM states SHALL be IDLE and SEND; reset enters IDLE.
REQ-015 IDLE -> SEND on an input handshake: the word is latched into the hold register and the beat counter is 0.
REQ-016 In SEND, m_valid_o SHALL be 1; m_data_o SHALL be hold[cnt*OUT_WIDTH +: OUT_WIDTH], least-significant beat first; m_last_o SHALL be (cnt == RATIO-1).
REQ-017 In IDLE, m_valid_o and m_last_o SHALL be 0, and m_data_o SHALL be 0.
REQ-018 An output handshake with m_last_o low SHALL increment cnt by 1.
REQ-019 An output handshake on the last beat SHALL wrap cnt to 0; the next state is SEND if an input handshake occurs in the same cycle (new word latched), otherwise IDLE.
REQ-020 s_ready_o SHALL be 1 in IDLE; in SEND it SHALL equal m_last_o AND m_ready_i, combinationally; otherwise 0.
REQ-021 Latency SHALL be: word accepted at edge N -> first beat valid after edge N, i.e. in the cycle following N.
REQ-022 Under continuous s_valid_i and m_ready_i, the output SHALL be bubble-free: one beat per cycle, and one word every RATIO cycles.
REQ-023 While m_valid_o is high and m_ready_i is low, m_data_o, m_last_o and cnt SHALL hold stable.
REQ-024 s_data_i SHALL be ignored whenever s_ready_o is low; the hold register changes only on an input handshake.

Reset
REQ-025 Assertion of rst_i SHALL immediately force IDLE, cnt=0, hold=0, m_valid_o=0, m_last_o=0, m_data_o=0 and s_ready_o=1, regardless of clk_i.
REQ-026 Reset during SEND SHALL discard the partially sent word; no further beats of that word are emitted after deassertion.
REQ-027 After deassertion, the first input handshake SHALL be possible at the first rising edge.

Structure
REQ-028 The FSM state typedef (IDLE, SEND) SHALL reside in a shared stream_pkg; the counter width SHALL use log2ceil from arithm_pkg.
REQ-029 The beat counter SHALL be an instance of the existing counter_param sub-module: width log2ceil(RATIO), reset driven by ~rst_i, increment on output handshake; wrap is natural.
REQ-030 All registers SHALL reside in one clocked process with asynchronous reset; the output and ready logic SHALL be combinational from state, cnt and hold.

Verification
REQ-031 Reset then s_data_i=32'hA1B2C3D4 with m_ready_i=1 -> beats B2? no: D4, C3, B2, A1 on consecutive cycles, m_last_o high only with A1.
REQ-032 Two back-to-back words 32'h03020100 and 32'h07060504, s_valid_i and m_ready_i held high -> 8 beats 00..07 with no gap; s_ready_o high exactly in the cycle of beat 03.
REQ-033 Word 32'hDEADBEEF, m_ready_i low for 3 cycles at beat 1 -> m_data_o stays 8'hBE while m_ready_i is low, then continues AD, DE; s_ready_o stays 0.
REQ-034 rst_i pulsed asynchronously mid-word after beat EF -> m_valid_o drops at once; after release, new word 32'h11223344 yields 44, 33, 22, 11 only.
REQ-035 Random s_valid_i/m_ready_i over 1000 words with a scoreboard -> beat stream equals the LSB-first concatenation of the words; m_last_o asserted every 4th beat.
